// File: rtl/sram_responder.sv
// Single-port RAM responder with level-held read/write request handshakes.
// Optional power-up array clear is enabled by defining SRAM_CLR_ON_RST_EN.
module sram_responder #(
  parameter int unsigned RAM_WIDTH    = 18,
  parameter int unsigned RAM_DEPTH    = 1024,
  parameter int unsigned READ_LATENCY = 2,
  parameter int unsigned WRITE_HOLD   = 2,
  localparam int unsigned ADDR_W      = $clog2(RAM_DEPTH - 1)
) (
  input  logic                 clk_i,
  input  logic                 rstn_i,
  input  logic                 mem_rd_i,
  input  logic                 mem_wr_i,
  input  logic [ADDR_W-1:0]    mem_addr_i,
  input  logic [RAM_WIDTH-1:0] mem_wr_data_i,
  output logic [RAM_WIDTH-1:0] mem_rd_data_o,
  output logic                 rd_valid_o,
  output logic                 wr_ack_o,
  output logic                 collision_o,
  output logic                 init_busy_o
);

  localparam logic [3:0] RdLat  = 4'(READ_LATENCY);
  localparam logic [3:0] WrHold = 4'(WRITE_HOLD);

  typedef enum logic [2:0] {
    StIdle,
    StRdBusy,
    StRdHold,
    StWrAccum,
    StWrDone
  } state_e;

  state_e               state_q, state_d;
  logic [3:0]           cnt_q, cnt_d, cnt_inc;
  logic [ADDR_W-1:0]    addr_q, addr_d;
  logic [RAM_WIDTH-1:0] data_q, data_d;
  logic [RAM_WIDTH-1:0] rd_data_q, rd_data_d;
  logic                 rd_valid_q, rd_valid_d;
  logic                 wr_ack_q, wr_ack_d;
  logic                 collision_q, collision_d;
  logic                 commit;
  logic                 clr_busy;
  logic                 rd_req, wr_req;
  logic                 addr_same, data_same;

  logic [RAM_WIDTH-1:0] mem [RAM_DEPTH];
  logic                 mem_we;
  logic [ADDR_W-1:0]    mem_waddr;
  logic [RAM_WIDTH-1:0] mem_wdata;

`ifdef SRAM_CLR_ON_RST_EN
  logic              clr_busy_q;
  logic [ADDR_W-1:0] clr_addr_q;

  // Reset parks the walker at address 0 so a mid-clear reset restarts it.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      clr_busy_q <= 1'b1;
      clr_addr_q <= '0;
    end else if (clr_busy_q) begin
      clr_addr_q <= clr_addr_q + 1'b1;
      if (clr_addr_q == ADDR_W'(RAM_DEPTH - 1)) begin
        clr_busy_q <= 1'b0;
      end
    end
  end

  assign clr_busy    = clr_busy_q;
  assign init_busy_o = clr_busy_q & rstn_i;
`else
  assign clr_busy    = 1'b0;
  assign init_busy_o = 1'b0;
`endif

  assign rd_req    = mem_rd_i & ~clr_busy;
  assign wr_req    = mem_wr_i & ~clr_busy;
  assign addr_same = (mem_addr_i == addr_q);
  assign data_same = (mem_wr_data_i == data_q);
  assign cnt_inc   = (cnt_q == 4'hF) ? cnt_q : cnt_q + 4'd1;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    data_d      = data_q;
    rd_data_d   = rd_data_q;
    rd_valid_d  = rd_valid_q;
    wr_ack_d    = 1'b0;
    commit      = 1'b0;
    collision_d = collision_q | (rd_req & wr_req);

    unique case (state_q)
      StIdle: begin
        rd_valid_d = 1'b0;
        if (rd_req) begin
          state_d = StRdBusy;
          addr_d  = mem_addr_i;
          cnt_d   = 4'd1;
        end else if (wr_req) begin
          state_d = StWrAccum;
          addr_d  = mem_addr_i;
          data_d  = mem_wr_data_i;
          cnt_d   = 4'd1;
        end
      end
      StRdBusy: begin
        if (!rd_req) begin
          state_d = StIdle;
        end else if (!addr_same) begin
          addr_d = mem_addr_i;
          cnt_d  = 4'd1;
        end else if (cnt_inc >= RdLat) begin
          // Count reached on this edge: data lands now, not one edge later.
          rd_data_d  = mem[addr_q];
          rd_valid_d = 1'b1;
          cnt_d      = cnt_inc;
          state_d    = StRdHold;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      StRdHold: begin
        if (!rd_req) begin
          state_d    = StIdle;
          rd_valid_d = 1'b0;
        end else if (!addr_same) begin
          state_d    = StRdBusy;
          addr_d     = mem_addr_i;
          cnt_d      = 4'd1;
          rd_valid_d = 1'b0;
        end
      end
      StWrAccum: begin
        if (rd_req) begin
          state_d = StRdBusy;
          addr_d  = mem_addr_i;
          cnt_d   = 4'd1;
        end else if (!wr_req) begin
          state_d = StIdle;
        end else if (!addr_same || !data_same) begin
          addr_d = mem_addr_i;
          data_d = mem_wr_data_i;
          cnt_d  = 4'd1;
        end else if (cnt_inc >= WrHold) begin
          commit   = 1'b1;
          wr_ack_d = 1'b1;
          cnt_d    = cnt_inc;
          state_d  = StWrDone;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      StWrDone: begin
        if (rd_req) begin
          state_d = StRdBusy;
          addr_d  = mem_addr_i;
          cnt_d   = 4'd1;
        end else if (!wr_req) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      addr_q      <= '0;
      data_q      <= '0;
      rd_data_q   <= '0;
      rd_valid_q  <= 1'b0;
      wr_ack_q    <= 1'b0;
      collision_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      rd_data_q   <= rd_data_d;
      rd_valid_q  <= rd_valid_d;
      wr_ack_q    <= wr_ack_d;
      collision_q <= collision_d;
    end
  end

  always_comb begin
    mem_we    = commit;
    mem_waddr = addr_q;
    mem_wdata = data_q;
`ifdef SRAM_CLR_ON_RST_EN
    if (clr_busy_q) begin
      mem_we    = 1'b1;
      mem_waddr = clr_addr_q;
      mem_wdata = '0;
    end
`endif
  end

  // Array has no reset; commit is only asserted out of a live WrAccum state.
  always_ff @(posedge clk_i) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  assign mem_rd_data_o = rd_data_q;
  assign rd_valid_o    = rd_valid_q;
  assign wr_ack_o      = wr_ack_q;
  assign collision_o   = collision_q;

endmodule

// File: tb/tb_sram_responder.sv
// Directed self-checking bench for sram_responder at default parameters.
module tb_sram_responder;

  logic        clk;
  logic        rstn;
  logic        mem_rd;
  logic        mem_wr;
  logic [9:0]  mem_addr;
  logic [17:0] mem_wr_data;
  logic [17:0] mem_rd_data;
  logic        rd_valid;
  logic        wr_ack;
  logic        collision;
  logic        init_busy;

  int checks = 0;
  int errors = 0;

  sram_responder dut (
    .clk_i         (clk),
    .rstn_i        (rstn),
    .mem_rd_i      (mem_rd),
    .mem_wr_i      (mem_wr),
    .mem_addr_i    (mem_addr),
    .mem_wr_data_i (mem_wr_data),
    .mem_rd_data_o (mem_rd_data),
    .rd_valid_o    (rd_valid),
    .wr_ack_o      (wr_ack),
    .collision_o   (collision),
    .init_busy_o   (init_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_word(input logic [9:0] a, input logic [17:0] d);
    mem_addr    = a;
    mem_wr_data = d;
    mem_wr      = 1'b1;
    step();
    step();
    mem_wr = 1'b0;
    step();
  endtask

  task automatic after_reset();
`ifdef SRAM_CLR_ON_RST_EN
    int n = 0;
    #1;
    while (init_busy && n < 2000) begin
      step();
      n++;
    end
    check("clear_len", n, 1024);
`else
    step();
`endif
  endtask

  initial begin
    int acks;
    rstn        = 1'b0;
    mem_rd      = 1'b0;
    mem_wr      = 1'b0;
    mem_addr    = '0;
    mem_wr_data = '0;
    #3;
    check("rst_rd_data", mem_rd_data, 0);
    check("rst_rd_valid", rd_valid, 0);
    check("rst_wr_ack", wr_ack, 0);
    check("rst_collision", collision, 0);
    check("rst_init_busy", init_busy, 0);
    repeat (2) @(posedge clk);
    #2 rstn = 1'b1;
    after_reset();

`ifdef SRAM_CLR_ON_RST_EN
    mem_addr = 10'h3FF;
    mem_rd   = 1'b1;
    step();
    step();
    check("clr_rd_3ff", mem_rd_data, 0);
    mem_rd = 1'b0;
    step();
`endif

    // Write then read back
    mem_addr    = 10'h005;
    mem_wr_data = 18'h2A5A5;
    mem_wr      = 1'b1;
    step();
    check("wr1_ack_e1", wr_ack, 0);
    step();
    check("wr1_ack_e2", wr_ack, 1);
    step();
    check("wr1_ack_e3", wr_ack, 0);
    mem_wr = 1'b0;
    step();
    mem_rd = 1'b1;
    step();
    check("rd1_valid_e1", rd_valid, 0);
    step();
    check("rd1_valid_e2", rd_valid, 1);
    check("rd1_data_e2", mem_rd_data, 32'h2A5A5);
    step();
    step();
    check("rd1_valid_e4", rd_valid, 1);
    mem_rd = 1'b0;
    step();
    check("rd1_valid_drop", rd_valid, 0);
    check("rd1_data_held", mem_rd_data, 32'h2A5A5);

    // Aborted write keeps prior contents
    wr_word(10'h010, 18'h0ABCD);
    mem_addr    = 10'h010;
    mem_wr_data = 18'h1FFFF;
    mem_wr      = 1'b1;
    step();
    mem_wr = 1'b0;
    mem_rd = 1'b1;
    step();
    check("abort_no_ack", wr_ack, 0);
    step();
    check("abort_rd_valid", rd_valid, 1);
    check("abort_rd_data", mem_rd_data, 32'h0ABCD);
    mem_rd = 1'b0;
    step();

    // Long-held write: exactly one commit
    acks        = 0;
    mem_addr    = 10'h020;
    mem_wr_data = 18'h15555;
    mem_wr      = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      if (wr_ack) acks++;
    end
    check("held_wr_acks", acks, 1);
    mem_wr = 1'b0;
    step();
    mem_rd = 1'b1;
    step();
    step();
    check("held_wr_data", mem_rd_data, 32'h15555);
    mem_rd = 1'b0;
    step();

    // Address change mid-read and mid-hold
    wr_word(10'h001, 18'h00111);
    wr_word(10'h002, 18'h00222);
    mem_addr = 10'h001;
    mem_rd   = 1'b1;
    step();
    check("achg_valid_e1", rd_valid, 0);
    mem_addr = 10'h002;
    step();
    check("achg_valid_e2", rd_valid, 0);
    step();
    check("achg_valid_e3", rd_valid, 1);
    check("achg_data_e3", mem_rd_data, 32'h00222);
    mem_addr = 10'h005;
    step();
    check("hold_chg_valid", rd_valid, 0);
    step();
    check("hold_chg_valid2", rd_valid, 1);
    check("hold_chg_data", mem_rd_data, 32'h2A5A5);
    mem_rd = 1'b0;
    step();

    // Collision: read wins, no commit, sticky flag
    wr_word(10'h030, 18'h00777);
    acks        = 0;
    mem_addr    = 10'h030;
    mem_wr_data = 18'h3FFFF;
    mem_rd      = 1'b1;
    mem_wr      = 1'b1;
    step();
    check("coll_flag", collision, 1);
    if (wr_ack) acks++;
    step();
    if (wr_ack) acks++;
    check("coll_rd_valid", rd_valid, 1);
    check("coll_rd_data", mem_rd_data, 32'h00777);
    step();
    if (wr_ack) acks++;
    check("coll_no_ack", acks, 0);
    mem_rd = 1'b0;
    mem_wr = 1'b0;
    step();
    check("coll_sticky", collision, 1);
    mem_rd = 1'b1;
    step();
    step();
    check("coll_no_commit", mem_rd_data, 32'h00777);
    mem_rd = 1'b0;
    step();

    // Async reset clears outputs immediately
    rstn = 1'b0;
    #1;
    check("rst2_collision", collision, 0);
    check("rst2_rd_data", mem_rd_data, 0);
    check("rst2_rd_valid", rd_valid, 0);
    check("rst2_wr_ack", wr_ack, 0);
    step();
    rstn = 1'b1;
    after_reset();

    // Array contents survive reset unless the clear feature is built in
    mem_addr = 10'h005;
    mem_rd   = 1'b1;
    step();
    step();
`ifdef SRAM_CLR_ON_RST_EN
    check("post_rst_data", mem_rd_data, 0);
`else
    check("post_rst_data", mem_rd_data, 32'h2A5A5);
`endif
    mem_rd = 1'b0;
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sram_responder.md
Name: sram_responder

Overview:
- Memory-side responder for the memory interface driven by the team's memory controller.
- Single-port synchronous RAM array with level-held request semantics.
- Read data is returned after a fixed number of held cycles. A write commits only after the request has been held for a fixed number of cycles.
- Sits directly below the controller and acts as the synthesizable/simulation backing store for the core's data path.

Parameters:
- RAM_WIDTH, 18, data word width in bits.
- RAM_DEPTH, 1024, number of words; power of two. ADDR_W = $clog2(RAM_DEPTH-1).
- READ_LATENCY, 2, consecutive sampled-high mem_rd_i cycles before data is registered. Legal 1..8; controller compatibility requires ≤4.
- WRITE_HOLD, 2, consecutive sampled-high mem_wr_i cycles before commit. Legal 1..8; controller compatibility requires ≤3.

Ports:
- clk_i  in  1  clock, rising edge
- rstn_i  in  1  asynchronous active-low reset
- mem_rd_i  in  1  read request, level, held by requester
- mem_wr_i  in  1  write request, level, held by requester
- mem_addr_i  in  ADDR_W  word address
- mem_wr_data_i  in  RAM_WIDTH  write data
- mem_rd_data_o  out  RAM_WIDTH  registered read data; holds last read value
- rd_valid_o  out  1  mem_rd_data_o belongs to the current held read
- wr_ack_o  out  1  one-cycle pulse on commit
- collision_o  out  1  sticky: mem_rd_i and mem_wr_i sampled high together
- init_busy_o  out  1  array clear in progress (see Optional Feature)

Behaviour:
- Reset (async assert): state IDLE, counter 0, all outputs 0. Array contents are not reset. An in-flight write is discarded, never partially committed.
- Counter cnt is 4 bits and saturates. A "sample" is a rising edge with the request high.
- IDLE:
  - mem_rd_i → RD_BUSY, latch addr, cnt=1.
  - Else mem_wr_i → WR_ACCUM, latch addr/data, cnt=1.
- RD_BUSY:
  - When cnt==READ_LATENCY: register mem[latched addr] to mem_rd_data_o, set rd_valid_o=1, go to RD_HOLD.
  - The check runs on the same edge that reaches the count, so READ_LATENCY=1 gives data one edge after the first sample.
  - mem_rd_i low → IDLE, data output unchanged.
  - Address change → restart with cnt=1.
  - Otherwise cnt++.
- RD_HOLD:
  - rd_valid_o=1 while mem_rd_i stays high at the same address.
  - mem_rd_i low → IDLE, rd_valid_o←0, data held.
  - Address change → RD_BUSY with cnt=1, rd_valid_o←0.
- WR_ACCUM:
  - mem_rd_i high → abort write, enter RD_BUSY with cnt=1 (read priority).
  - mem_wr_i low → abort, IDLE, no array change.
  - Address or data change → restart with cnt=1.
  - When cnt==WRITE_HOLD: mem[addr]←data, wr_ack_o=1 for one cycle, go to WR_DONE.
- WR_DONE:
  - No further writes while mem_wr_i stays high (one commit per request).
  - mem_wr_i low → IDLE.
  - mem_rd_i → RD_BUSY.
- Simultaneous mem_rd_i & mem_wr_i in any state: read path wins and collision_o←1 until reset.
- Read-after-write to the same address returns the committed data. No bypass is needed because a commit precedes any read start.
- Controller timing at defaults:
  - Read data is stable from the 2nd sample onward, well before the 4th sample.
  - A write commits on the 2nd of the 3 held cycles.

Optional Feature:
- Macro SRAM_CLR_ON_RST_EN.
- Defined:
  - After rstn_i deasserts, a clear counter walks addresses 0..RAM_DEPTH-1 writing 0, one word per cycle.
  - init_busy_o=1 for exactly RAM_DEPTH cycles.
  - Requests are ignored during the clear (state stays IDLE, no ack, collision not flagged).
  - Reset asserted mid-clear restarts the clear from address 0.
- Undefined: init_busy_o tied 0, no clear logic, array uninitialised.

Test Plan:
- Write then read: wr addr 0x005 data 0x2A5A5 held 3 cycles → wr_ack_o pulses on the 2nd edge. Then rd addr 0x005 held 4 cycles → mem_rd_data_o=0x2A5A5 and rd_valid_o=1 from the 2nd edge.
- Aborted write: wr addr 0x010 data 0x1FFFF held 1 cycle then mem_rd_i addr 0x010 → no wr_ack_o, and the read returns the prior contents of 0x010.
- Held write: mem_wr_i held 10 cycles at addr 0x020 → exactly one wr_ack_o pulse and one commit.
- Address change mid-read: rd 0x001 for 1 cycle then 0x002 → data from 0x002 after 2 further edges, rd_valid_o never high for 0x001.
- Collision and reset: mem_rd_i and mem_wr_i high together → collision_o=1, read serviced, no commit. Then pulse rstn_i low → collision_o=0 and all outputs 0 immediately.
- With SRAM_CLR_ON_RST_EN: release reset → init_busy_o high for 1024 cycles. Reading addr 0x3FF afterwards returns 0.
